lfsr_gaus_reader: RTL and testbench

Consumer end of the 56-bit Gaussian LFSR stream. The block samples the free-running 56-bit pseudo-random word and forms an approximately Gaussian 16-bit signed sample by central-limit summation of four 14-bit slices, with the mean removed. Samples are buffered in a small FIFO and handed to downstream LBM collision logic over a valid/ready handshake. The block also watches the incoming stream and flags a stalled or locked-up LFSR.

---
 rtl/lfsr_gaus_reader.sv | 116 +++++++++++
 tb/tb_lfsr_gaus_reader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gaus_reader.sv
// Turns the 56-bit LFSR word into a zero-mean 16-bit sample by summing four 14-bit slices.
// Samples queue in a fall-through FIFO; a detector flags a frozen input stream.
module lfsr_gaus_reader #(
    parameter int DEPTH        = 8,
    parameter int STUCK_CYCLES = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     enable,
    input  logic [55:0]              rand_in,
    input  logic                     clear_stuck,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [15:0]              out_sample,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     lfsr_stuck,
    output logic [31:0]              sample_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STUCK_CYCLES + 1);

    logic [15:0]            sum_q, sum_d;
    logic                   v1_q, v1_d;
    logic [15:0]            cent_q, cent_d;
    logic                   v2_q, v2_d;
    logic [DEPTH-1:0][15:0] mem_q, mem_d;
    logic [AW-1:0]          wptr_q, wptr_d;
    logic [AW-1:0]          rptr_q, rptr_d;
    logic [AW:0]            count_q, count_d;
    logic [31:0]            scnt_q, scnt_d;
    logic [55:0]            prev_q, prev_d;
    logic [SW-1:0]          stk_cnt_q, stk_cnt_d;
    logic                   stuck_q, stuck_d;

    logic                   capture;
    logic                   push;
    logic                   pop;
    logic [AW+1:0]          occupancy;

    always_comb begin
        // Count in-flight samples so the FIFO can never be overrun, even with no pops.
        occupancy = {1'b0, count_q} + (AW+2)'(v1_q) + (AW+2)'(v2_q);
        capture   = enable && !stuck_q && (occupancy < (AW+2)'(DEPTH));
        push      = v2_q;
        pop       = (count_q != '0) && out_ready;

        v1_d  = capture;
        sum_d = sum_q;
        if (capture)
            sum_d = {2'b00, rand_in[13:0]}  + {2'b00, rand_in[27:14]}
                  + {2'b00, rand_in[41:28]} + {2'b00, rand_in[55:42]};

        v2_d   = v1_q;
        cent_d = v1_q ? (sum_q - 16'd32766) : cent_q;

        mem_d = mem_q;
        if (push)
            mem_d[wptr_q] = cent_q;
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        scnt_d = pop ? scnt_q + 32'd1 : scnt_q;

        prev_d = rand_in;
        if (clear_stuck || rand_in != prev_q)
            stk_cnt_d = '0;
        else if (stk_cnt_q == SW'(STUCK_CYCLES))
            stk_cnt_d = stk_cnt_q;
        else
            stk_cnt_d = stk_cnt_q + SW'(1);
        stuck_d = !clear_stuck && (stuck_q || stk_cnt_d == SW'(STUCK_CYCLES));
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sum_q     <= '0;
            v1_q      <= 1'b0;
            cent_q    <= '0;
            v2_q      <= 1'b0;
            mem_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            scnt_q    <= '0;
            prev_q    <= '0;
            stk_cnt_q <= '0;
            stuck_q   <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            v1_q      <= v1_d;
            cent_q    <= cent_d;
            v2_q      <= v2_d;
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            scnt_q    <= scnt_d;
            prev_q    <= prev_d;
            stk_cnt_q <= stk_cnt_d;
            stuck_q   <= stuck_d;
        end
    end

    assign out_valid    = (count_q != '0);
    assign out_sample   = out_valid ? mem_q[rptr_q] : 16'h0000;
    assign fifo_count   = count_q;
    assign lfsr_stuck   = stuck_q;
    assign sample_count = scnt_q;
endmodule

// File: tb/tb_lfsr_gaus_reader.sv
// Bench for lfsr_gaus_reader: directed table, corner-case sequences and a random run
// checked against a queue-based model of the sample stream.
module tb_lfsr_gaus_reader;
    localparam int DEPTH = 8;
    localparam int STUCK = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        enable = 1'b0;
    logic [55:0] rand_in = '0;
    logic        clear_stuck = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_sample;
    logic [3:0]  fifo_count;
    logic        lfsr_stuck;
    logic [31:0] sample_count;

    int checks = 0;
    int errors = 0;

    lfsr_gaus_reader #(.DEPTH(DEPTH), .STUCK_CYCLES(STUCK)) dut (
        .Clk(Clk), .Reset(Reset), .enable(enable), .rand_in(rand_in),
        .clear_stuck(clear_stuck), .out_ready(out_ready), .out_valid(out_valid),
        .out_sample(out_sample), .fifo_count(fifo_count), .lfsr_stuck(lfsr_stuck),
        .sample_count(sample_count)
    );

    always #5 Clk = ~Clk;

    // Reference model: FIFO contents, samples in flight with edges-to-land, stuck bookkeeping.
    typedef struct { logic [15:0] v; int age; } fl_t;
    logic [15:0] mq[$];
    fl_t         pipe[$];
    int          m_sc;
    logic        m_stuck;
    int          m_run;
    logic [55:0] m_prev;

    function automatic logic [15:0] gauss(input logic [55:0] r);
        int s;
        s = int'(r[13:0]) + int'(r[27:14]) + int'(r[41:28]) + int'(r[55:42]);
        return 16'(s - 32766);
    endfunction

    function automatic logic [55:0] rnd56();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[55:0];
    endfunction

    task automatic model_reset();
        mq.delete();
        pipe.delete();
        m_sc = 0;
        m_stuck = 1'b0;
        m_run = 0;
        m_prev = '0;
    endtask

    task automatic model_edge();
        bit cap;
        cap = enable && !m_stuck && ((mq.size() + pipe.size()) < DEPTH);
        if (mq.size() > 0 && out_ready) begin
            void'(mq.pop_front());
            m_sc++;
        end
        for (int i = 0; i < pipe.size(); i++) pipe[i].age--;
        while (pipe.size() > 0 && pipe[0].age == 0) begin
            mq.push_back(pipe[0].v);
            void'(pipe.pop_front());
        end
        if (cap) pipe.push_back('{gauss(rand_in), 2});
        if (clear_stuck) begin
            m_run = 0;
            m_stuck = 1'b0;
        end else begin
            m_run = (rand_in == m_prev) ? ((m_run < STUCK) ? m_run + 1 : STUCK) : 0;
            if (m_run == STUCK) m_stuck = 1'b1;
        end
        m_prev = rand_in;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("m_count", 64'(fifo_count), 64'(mq.size()));
        chk("m_stuck", 64'(lfsr_stuck), 64'(m_stuck));
        chk("m_sc", 64'(sample_count), 64'(m_sc));
        if (mq.size() != 0) chk("m_sample", 64'(out_sample), 64'(mq[0]));
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        enable = 1'b0;
        out_ready = 1'b0;
        clear_stuck = 1'b0;
        rand_in = '0;
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    typedef struct {
        logic        en;
        logic [55:0] r;
        logic        rdy;
        logic        ev;
        logic [15:0] es;
        int          ec;
        int          esc;
    } vec_t;
    vec_t tbl[11];

    initial begin
        logic [55:0] wm, wm2, wf, wz, hold_r;
        logic [15:0] bp[8];
        logic [15:0] newv;

        wm  = {4{14'h1FFF}};
        wm2 = {14'd8191, 14'd8191, 14'd8192, 14'd8190};
        wf  = 56'hFF_FFFF_FFFF_FFFF;
        wz  = '0;
        tbl[0]  = '{1'b1, wm,  1'b1, 1'b0, 16'h0000, 0, 0};
        tbl[1]  = '{1'b1, wm2, 1'b1, 1'b0, 16'h0000, 0, 0};
        tbl[2]  = '{1'b1, wm,  1'b1, 1'b1, 16'hFFFE, 1, 0};
        tbl[3]  = '{1'b1, wm2, 1'b1, 1'b1, 16'hFFFE, 1, 1};
        tbl[4]  = '{1'b1, wm,  1'b1, 1'b1, 16'hFFFE, 1, 2};
        tbl[5]  = '{1'b1, wf,  1'b1, 1'b1, 16'hFFFE, 1, 3};
        tbl[6]  = '{1'b1, wz,  1'b1, 1'b1, 16'hFFFE, 1, 4};
        tbl[7]  = '{1'b1, wf,  1'b1, 1'b1, 16'h7FFE, 1, 5};
        tbl[8]  = '{1'b1, wz,  1'b1, 1'b1, 16'h8002, 1, 6};
        tbl[9]  = '{1'b1, wf,  1'b1, 1'b1, 16'h7FFE, 1, 7};
        tbl[10] = '{1'b1, wz,  1'b1, 1'b1, 16'h8002, 1, 8};

        do_reset();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_sample", 64'(out_sample), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_stuck", 64'(lfsr_stuck), 64'd0);
        chk("rst_sc", 64'(sample_count), 64'd0);

        // Mean and extreme words, streamed with a ready consumer.
        for (int i = 0; i < 11; i++) begin
            enable = tbl[i].en;
            rand_in = tbl[i].r;
            out_ready = tbl[i].rdy;
            step();
            chk("tbl_valid", 64'(out_valid), 64'(tbl[i].ev));
            chk("tbl_count", 64'(fifo_count), 64'(tbl[i].ec));
            chk("tbl_sc", 64'(sample_count), 64'(tbl[i].esc));
            chk("tbl_stuck", 64'(lfsr_stuck), 64'd0);
            if (tbl[i].ev) chk("tbl_sample", 64'(out_sample), 64'(tbl[i].es));
        end

        // Backpressure: fill to DEPTH, hold, then drain in capture order.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 15; i++) begin
            rand_in = rnd56();
            if (i < 8) bp[i] = gauss(rand_in);
            step();
            check_model();
        end
        chk("bp_full", 64'(fifo_count), 64'd8);
        enable = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("bp_order", 64'(out_sample), 64'(bp[i]));
            rand_in = rnd56();
            step();
            check_model();
        end
        chk("bp_sc", 64'(sample_count), 64'd8);
        chk("bp_empty", 64'(out_valid), 64'd0);
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_in = rnd56();
            step();
            check_model();
        end

        // Push and pop on the same edge keep the count steady.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_in = rnd56();
            step();
        end
        chk("pp_pre", 64'(fifo_count), 64'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_in = rnd56();
            step();
            chk("pp_count", 64'(fifo_count), 64'd4);
            check_model();
        end

        // Stuck input: flag on the fourth repeat, drain, then clear.
        do_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_in = rnd56();
            step();
        end
        hold_r = rnd56();
        for (int i = 0; i < 5; i++) begin
            rand_in = hold_r;
            step();
            chk("stuck_rise", 64'(lfsr_stuck), 64'(i == 4));
            check_model();
        end
        for (int i = 0; i < 5; i++) begin
            step();
            check_model();
        end
        chk("stuck_drained", 64'(out_valid), 64'd0);
        chk("stuck_hold", 64'(lfsr_stuck), 64'd1);
        clear_stuck = 1'b1;
        rand_in = rnd56();
        step();
        clear_stuck = 1'b0;
        chk("stuck_clear", 64'(lfsr_stuck), 64'd0);
        for (int i = 0; i < 3; i++) begin
            rand_in = rnd56();
            step();
            check_model();
        end
        chk("stuck_resume", 64'(out_valid), 64'd1);
        hold_r = rnd56();
        rand_in = hold_r;
        for (int i = 0; i < 4; i++) step();
        clear_stuck = 1'b1;
        step();
        clear_stuck = 1'b0;
        chk("clear_wins", 64'(lfsr_stuck), 64'd0);
        check_model();

        // Asynchronous reset with a partly full FIFO and both stages busy.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rand_in = rnd56();
            step();
        end
        chk("mid_pre", 64'(fifo_count), 64'd5);
        #1;
        Reset = 1'b0;
        #1;
        chk("mid_valid", 64'(out_valid), 64'd0);
        chk("mid_sample", 64'(out_sample), 64'd0);
        chk("mid_count", 64'(fifo_count), 64'd0);
        chk("mid_stuck", 64'(lfsr_stuck), 64'd0);
        chk("mid_sc", 64'(sample_count), 64'd0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;
        rand_in = rnd56();
        newv = gauss(rand_in);
        step();
        for (int i = 0; i < 2; i++) begin
            rand_in = rnd56();
            step();
        end
        chk("mid_new_count", 64'(fifo_count), 64'd1);
        chk("mid_new_sample", 64'(out_sample), 64'(newv));
        check_model();

        // Random traffic against the model.
        do_reset();
        hold_r = rnd56();
        for (int i = 0; i < 500; i++) begin
            enable = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 5);
            clear_stuck = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) >= 4) hold_r = rnd56();
            rand_in = hold_r;
            step();
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
